// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state encodings
//   arb_gnt_e   : which requester owns the memory
//   CntW        : wait-state counter width (supports LAT up to 15)
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntFetch = 1'b0,
    GntData  = 1'b1
  } arb_gnt_e;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable 4-bit down-counter that times the BUSY phase of a memory access.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears the count)
//   i_load         : load i_load_val (takes priority over i_dec)
//   i_load_val     : value loaded on i_load
//   i_dec          : decrement by one; holds at zero
//   o_zero         : count is zero
module arb_wait_counter
  import unified_mem_arbiter_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [CntW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency unified memory between the fetch port and
// the data port. Each transaction: IDLE (arbitrate) -> BUSY for LAT cycles ->
// RESP (one-cycle ready pulse) -> IDLE.
// Build option: define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous
// requests; otherwise data always beats fetch.
// Parameters: ADDR_W, DATA_W, LAT (memory cycles per access, 1..15).
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_if_req/i_if_addr       : fetch request and address
//   o_if_rdata/o_if_ready    : registered fetch word, completion pulse
//   i_d_req/i_d_we/i_d_addr/i_d_wdata : data request, store flag, address, data
//   o_d_rdata/o_d_ready      : registered load word, completion pulse
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata : memory interface
//   o_busy                   : arbiter not idle
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  // Counter is loaded with LAT-1 so it reads zero in the last BUSY cycle.
  localparam logic [CntW-1:0] LoadVal = CntW'(LAT - 1);

  arb_state_e r_state, w_state_next;
  arb_gnt_e   r_gnt, w_gnt_next;
  arb_gnt_e   w_pick;
  logic       w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic       w_in_busy, w_in_resp, w_data_gnt, w_last_beat;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;

  // Arbitration between requesters present in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  arb_gnt_e r_last;

  always_comb begin
    w_pick = GntFetch;
    if (i_d_req && i_if_req) begin
      if (r_last == GntData) begin
        w_pick = GntFetch;
      end else begin
        w_pick = GntData;
      end
    end else if (i_d_req) begin
      w_pick = GntData;
    end
  end

  // Resets to FETCH so data wins the first conflict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= GntFetch;
    end else if (w_cnt_load) begin
      r_last <= w_pick;
    end
  end
`else
  always_comb begin
    w_pick = GntFetch;
    if (i_d_req) begin
      w_pick = GntData;
    end
  end
`endif

  arb_wait_counter u_wait_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (LoadVal),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_d_req || i_if_req) begin
          w_gnt_next   = w_pick;
          w_cnt_load   = 1'b1;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_gnt   <= GntData;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
    end
  end

  assign w_in_busy   = (r_state == StBusy);
  assign w_in_resp   = (r_state == StResp);
  assign w_data_gnt  = (r_gnt == GntData);
  assign w_last_beat = w_in_busy && w_cnt_zero;

  // Stores leave the load register untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_last_beat) begin
      if (!w_data_gnt) begin
        r_if_rdata <= i_mem_rdata;
      end else if (!i_d_we) begin
        r_d_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_en    = w_in_busy;
  assign o_mem_we    = w_in_busy && w_data_gnt && i_d_we;
  assign o_mem_addr  = !w_in_busy ? '0 : (w_data_gnt ? i_d_addr : i_if_addr);
  assign o_mem_wdata = (w_in_busy && w_data_gnt) ? i_d_wdata : '0;
  assign o_if_ready  = w_in_resp && !w_data_gnt;
  assign o_d_ready   = w_in_resp && w_data_gnt;
  assign o_busy      = (r_state != StIdle);
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one fixed-latency unified instruction/data memory between the pipeline's fetch port and its data-memory port.
- Sequences each access with a three-state FSM and a wait-state counter.
- Returns read data and a one-cycle ready pulse per completed transaction; the hazard logic stalls IF/MEM on a deasserted ready.
- Sits between the datapath and the memory model, beneath the RISCV top.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word, registered.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load word, registered.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last BUSY cycle.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (rst=0, any time, including mid-transaction):
  - state goes to IDLE; the counter clears; the grant register goes to DATA.
  - All outputs are 0. An aborted transaction produces no ready pulse.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If d_req=1, grant DATA; otherwise, if if_req=1, grant FETCH.
  - On a grant, load cnt=LAT-1 and go to BUSY. With no request, stay in IDLE.
- BUSY:
  - mem_en=1. mem_addr, mem_we and mem_wdata are muxed from the granted requester by the registered grant.
  - mem_we=d_we only when DATA is granted; otherwise mem_we=0.
  - Each cycle, cnt decrements. On the cycle with cnt==0:
    - capture mem_rdata into if_rdata or d_rdata, per the grant. Capture only on loads or fetches; stores leave d_rdata unchanged.
    - go to RESP.
- RESP:
  - The granted ready output is 1 for exactly this cycle; mem_en=0.
  - Next state is always IDLE.
- Timing:
  - Request seen at edge t: mem_en is high for cycles t+1..t+LAT; ready pulses in cycle t+LAT+1.
  - Minimum spacing between consecutive grants is LAT+2 cycles.
  - LAT=1 gives a single BUSY cycle.
- Requests are sampled only in IDLE. A request arriving in BUSY or RESP waits.
- If a requester drops req mid-transaction, the transaction still completes and its ready still pulses. The held address and data must remain stable; a violation is undefined, not detected.
- Simultaneous if_req and d_req in IDLE: DATA wins under fixed priority, because data belongs to the older instruction.
- Back-to-back: a requester that keeps req high after its ready is re-arbitrated in the following IDLE cycle.
- mem_addr and mem_wdata are 0 outside BUSY.
- if_ready and d_ready are never high in the same cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request in IDLE, the requester not served last wins. The "last served" register resets to FETCH, so data wins the first conflict. A single requester is always granted.
- Undefined: fixed data-over-fetch priority as described above. Fetch can starve under continuous d_req.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - grant encodings GNT_FETCH=1'b0, GNT_DATA=1'b1.
- One sub-module, arb_wait_counter:
  - loadable down-counter, 4 bits;
  - inputs load and dec;
  - output zero flag.

Test Plan:
- Reset then a fetch-only read: LAT=2, if_req=1 with if_addr=0x10 and mem_rdata=0x00500093. Expect mem_en high for 2 cycles, then if_ready for 1 cycle and if_rdata=0x00500093, both on cycle t+3.
- Simultaneous if_req and d_req (load at 0x200): d_ready first. Then the fetch is granted in the IDLE cycle after RESP, with if_ready at t+LAT+1 relative to that IDLE.
- Store with d_we=1, d_addr=0x104, d_wdata=0xDEADBEEF: mem_we=1 and mem_wdata=0xDEADBEEF throughout BUSY; d_ready pulses; d_rdata is unchanged.
- Continuous d_req plus if_req with ARB_ROUND_ROBIN_EN: grants alternate D, F, D, F. Without the macro, every grant goes to D.
- rst pulled low in the second BUSY cycle: all outputs go to 0 immediately and no ready pulse follows. After release with both requests high, DATA is granted.
- LAT=1: request to ready in 2 cycles; steady-state throughput of one transaction per 3 cycles.
